// File: rtl/mat_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg: shared types and width helpers for the sequential N x N matrix
// multiplier (mat_mult_seq) and its multiply-accumulate unit (mat_mac).
//   mm_state_t : controller states IDLE / MAC / OUT / DONE
//   idx_width  : index counter width, max(1, clog2(N))
//   acc_width  : accumulator width, 2*DATA_W + clog2(N); wide enough for N
//                full-scale products, so the sum can never wrap
//   max_int    : larger of two integers (used to size comparisons)
// -----------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } mm_state_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mat_mult_seq_mac.sv
// -----------------------------------------------------------------------------
// mat_mac: single multiply-accumulate unit for mat_mult_seq.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the accumulator (start of a new element)
//   en         : add a*b into the accumulator this cycle
//   a, b       : unsigned operands, DATA_W bits
//   sum        : accumulator + a*b, i.e. the value the accumulator takes on
//                an enabled edge; lets the controller capture the final sum
//                on the same edge as the last product is added
// -----------------------------------------------------------------------------
module mat_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    acc_r;

  // Full-width product and the running sum including it
  always_comb begin
    prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum    = acc_r + ACC_W'(prod_s);
  end

  // Accumulator register: cleared per element, advanced once per MAC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum;
    end
  end

endmodule

// File: rtl/mat_mult_seq.sv
// -----------------------------------------------------------------------------
// mat_mult_seq: sequential N x N unsigned matrix multiplier, C = A * B, using
// one MAC per cycle. Operands are latched on start; each C element is streamed
// in row-major order over a valid/ready handshake.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : request, sampled only while idle
//   a_flat, b_flat     : operand matrices, element [r][c] at (r*N+c)*DATA_W
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse after the last element is accepted
//   out_valid/out_ready: result handshake
//   out_data           : C[out_row][out_col]
//   out_row, out_col   : element indices
//   out_sat            : element was clamped (only with MATMUL_SAT_EN)
// Build option: define MATMUL_SAT_EN to saturate results to 2^RES_W-1;
// otherwise results are truncated modulo 2^RES_W.
// -----------------------------------------------------------------------------
module mat_mult_seq
  import matmul_pkg::*;
#(
  parameter int  N      = 3,
  parameter int  DATA_W = 8,
  parameter int  RES_W  = 16,
  localparam int IDX_W  = idx_width(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*N*DATA_W-1:0]   a_flat,
  input  logic [N*N*DATA_W-1:0]   b_flat,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_row,
  output logic [IDX_W-1:0]        out_col
`ifdef MATMUL_SAT_EN
  ,
  output logic                    out_sat
`endif
);

  localparam int ACC_W  = acc_width(DATA_W, N);
  localparam int CMP_W  = max_int(ACC_W, RES_W);
  localparam int FLAT_W = $clog2(N * N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  mm_state_t          state_r, next_state_s;
  logic [DATA_W-1:0]  a_mem_r [N*N];
  logic [DATA_W-1:0]  b_mem_r [N*N];
  logic [IDX_W-1:0]   i_r, j_r, k_r;
  logic [FLAT_W-1:0]  a_idx_s, b_idx_s;
  logic [ACC_W-1:0]   sum_s;
  logic [CMP_W-1:0]   sum_ext_s;
  logic [RES_W-1:0]   res_s;
  logic               accept_s, last_k_s, last_elem_s;
  logic               mac_clear_s, mac_en_s;
  logic               busy_nx_s, valid_nx_s, done_nx_s;
`ifdef MATMUL_SAT_EN
  localparam logic [CMP_W-1:0] RES_MAX = CMP_W'({RES_W{1'b1}});
  logic               sat_s;
`endif

  // Operand selection and iteration status
  always_comb begin
    a_idx_s     = FLAT_W'(i_r) * FLAT_W'(N) + FLAT_W'(k_r);
    b_idx_s     = FLAT_W'(k_r) * FLAT_W'(N) + FLAT_W'(j_r);
    last_k_s    = (k_r == LAST_IDX);
    last_elem_s = (i_r == LAST_IDX) && (j_r == LAST_IDX);
    accept_s    = out_valid && out_ready;
  end

  mat_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear_s),
    .en    (mac_en_s),
    .a     (a_mem_r[a_idx_s]),
    .b     (b_mem_r[b_idx_s]),
    .sum   (sum_s)
  );

  // Reduction of the final sum to the output width
  always_comb begin
    sum_ext_s = CMP_W'(sum_s);
`ifdef MATMUL_SAT_EN
    if (sum_ext_s > RES_MAX) begin
      res_s = {RES_W{1'b1}};
      sat_s = 1'b1;
    end else begin
      res_s = RES_W'(sum_ext_s);
      sat_s = 1'b0;
    end
`else
    res_s = RES_W'(sum_ext_s);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = MAC;
        else       next_state_s = IDLE;
      end
      MAC: begin
        if (last_k_s) next_state_s = OUT;
        else          next_state_s = MAC;
      end
      OUT: begin
        if (accept_s) next_state_s = last_elem_s ? DONE : MAC;
        else          next_state_s = OUT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered status outputs, MAC control.
  // done is registered off the DONE state so it shows in the cycle after it.
  always_comb begin
    busy_nx_s   = (next_state_s != IDLE);
    valid_nx_s  = (next_state_s == OUT);
    done_nx_s   = (state_r == DONE);
    mac_en_s    = (state_r == MAC);
    mac_clear_s = ((state_r == IDLE) && start) || ((state_r == OUT) && accept_s);
  end

  // Operand latch and i/j/k iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < N * N; e++) begin
        a_mem_r[e] <= '0;
        b_mem_r[e] <= '0;
      end
      i_r <= '0;
      j_r <= '0;
      k_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < N * N; e++) begin
              a_mem_r[e] <= a_flat[e*DATA_W +: DATA_W];
              b_mem_r[e] <= b_flat[e*DATA_W +: DATA_W];
            end
            i_r <= '0;
            j_r <= '0;
            k_r <= '0;
          end
        end
        MAC: begin
          k_r <= last_k_s ? '0 : k_r + IDX_W'(1);
        end
        OUT: begin
          if (accept_s && !last_elem_s) begin
            if (j_r == LAST_IDX) begin
              j_r <= '0;
              i_r <= i_r + IDX_W'(1);
            end else begin
              j_r <= j_r + IDX_W'(1);
            end
            k_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status outputs and the result element (captured with the last product)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
`ifdef MATMUL_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      busy      <= busy_nx_s;
      done      <= done_nx_s;
      out_valid <= valid_nx_s;
      if ((state_r == MAC) && last_k_s) begin
        out_data <= res_s;
        out_row  <= i_r;
        out_col  <= j_r;
`ifdef MATMUL_SAT_EN
        out_sat  <= sat_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mat_mult_seq: directed self-checking bench for mat_mult_seq.
// Instance dut3 uses the default N=3, DATA_W=8; instance dut4 uses N=4,
// DATA_W=4. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mat_mult_seq;

  logic        clk;
  logic        reset;

  logic        start0, busy0, done0, valid0, ready0;
  logic [71:0] a_flat0, b_flat0;
  logic [15:0] data0;
  logic [1:0]  row0, col0;
  logic        sat0;

  logic        start1, busy1, done1, valid1, ready1;
  logic [63:0] a_flat1, b_flat1;
  logic [15:0] data1;
  logic [1:0]  row1, col1;
  logic        sat1;

  int errors = 0;
  int checks = 0;

  mat_mult_seq dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start0),
    .a_flat    (a_flat0),
    .b_flat    (b_flat0),
    .busy      (busy0),
    .done      (done0),
    .out_valid (valid0),
    .out_ready (ready0),
    .out_data  (data0),
    .out_row   (row0),
    .out_col   (col0)
`ifdef MATMUL_SAT_EN
    ,
    .out_sat   (sat0)
`endif
  );

  mat_mult_seq #(.N(4), .DATA_W(4), .RES_W(16)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .a_flat    (a_flat1),
    .b_flat    (b_flat1),
    .busy      (busy1),
    .done      (done1),
    .out_valid (valid1),
    .out_ready (ready1),
    .out_data  (data1),
    .out_row   (row1),
    .out_col   (col1)
`ifdef MATMUL_SAT_EN
    ,
    .out_sat   (sat1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack3(input int m [9]);
    logic [71:0] p;
    p = '0;
    for (int e = 0; e < 9; e++) p[e*8 +: 8] = 8'(m[e]);
    return p;
  endfunction

  // Runs one 3x3 job on dut3 starting from a falling edge with operands set.
  // stall: cycles out_ready is held low per element; poke_cyc: cycle with a
  // stray start and new operands; rst_cyc: cycle reset is asserted (-1 = none).
  task automatic run3(input string tag, input int exp_d [9], input logic exp_s,
                      input int stall, input int poke_cyc, input int rst_cyc);
    int idx, cyc, first_v, done_c, st;
    int all255 [9];
    idx = 0; cyc = 0; first_v = -1; done_c = -1; st = 0;
    for (int e = 0; e < 9; e++) all255[e] = 255;
    ready0 = (stall == 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < 400 && done_c < 0) begin
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        #1;
        check({tag, ".rst_busy"},  32'(busy0),  32'd0);
        check({tag, ".rst_valid"}, 32'(valid0), 32'd0);
        check({tag, ".rst_done"},  32'(done0),  32'd0);
        check({tag, ".rst_data"},  32'(data0),  32'd0);
        check({tag, ".rst_row"},   32'(row0),   32'd0);
        check({tag, ".rst_col"},   32'(col0),   32'd0);
        @(negedge clk);
        reset  = 1'b0;
        ready0 = 1'b1;
        return;
      end
      start0 = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        a_flat0 = pack3(all255);
        b_flat0 = pack3(all255);
      end
      if (valid0) begin
        if (first_v < 0) first_v = cyc;
        if (idx >= 9) begin
          check({tag, ".extra_elem"}, 32'(idx), 32'd8);
          ready0 = 1'b1;
        end else if (st < stall) begin
          ready0 = 1'b0;
          check({tag, ".held_data"}, 32'(data0), 32'(exp_d[idx]));
          check({tag, ".held_row"},  32'(row0),  32'(idx / 3));
          st++;
        end else begin
          ready0 = 1'b1;
          check({tag, ".data"}, 32'(data0), 32'(exp_d[idx]));
          check({tag, ".row"},  32'(row0),  32'(idx / 3));
          check({tag, ".col"},  32'(col0),  32'(idx % 3));
`ifdef MATMUL_SAT_EN
          check({tag, ".sat"},  32'(sat0),  32'(exp_s));
`endif
          idx++;
          st = 0;
        end
      end else begin
        ready0 = (stall == 0);
      end
      if (done0) begin
        done_c = cyc;
        check({tag, ".busy_at_done"}, 32'(busy0), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".count"},       32'(idx),     32'd9);
    check({tag, ".first_valid"}, 32'(first_v), 32'd3);
    check({tag, ".done_cycle"},  32'(done_c),  32'(37 + 9 * stall));
    check({tag, ".done_pulse"},  32'(done0),   32'd0);
    ready0 = 1'b1;
  endtask

  initial begin
    int ident [9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int seq9 [9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int ones [9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int full [9]   = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    int threes [9] = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    int ovf [9];
    logic ovf_sat;
    int cyc, idx, done_c;

`ifdef MATMUL_SAT_EN
    for (int e = 0; e < 9; e++) ovf[e] = 65535;
    ovf_sat = 1'b1;
`else
    for (int e = 0; e < 9; e++) ovf[e] = 64003;
    ovf_sat = 1'b0;
`endif

    reset   = 1'b1;
    start0  = 1'b0; ready0 = 1'b1; a_flat0 = '0; b_flat0 = '0;
    start1  = 1'b0; ready1 = 1'b1; a_flat1 = '0; b_flat1 = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",  32'(busy0),  32'd0);
    check("reset.valid", 32'(valid0), 32'd0);
    check("reset.done",  32'(done0),  32'd0);
    check("reset.data",  32'(data0),  32'd0);
    check("reset.row",   32'(row0),   32'd0);
    check("reset.col",   32'(col0),   32'd0);
    check("reset.busy4", 32'(busy1),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Identity times 1..9
    a_flat0 = pack3(ident);
    b_flat0 = pack3(seq9);
    run3("identity", seq9, 1'b0, 0, -1, -1);

    // Overflow: 3 * 255 * 255 = 195075
    a_flat0 = pack3(full);
    b_flat0 = pack3(full);
    run3("overflow", ovf, ovf_sat, 0, -1, -1);

    // Backpressure: all-ones gives 3 everywhere, 5 stall cycles per element
    a_flat0 = pack3(ones);
    b_flat0 = pack3(ones);
    run3("backpressure", threes, 1'b0, 5, -1, -1);

    // Start while busy, with operand changes, must be ignored
    a_flat0 = pack3(ident);
    b_flat0 = pack3(seq9);
    run3("start_busy", seq9, 1'b0, 0, 10, -1);

    // Reset mid-operation, then a full run
    a_flat0 = pack3(ident);
    b_flat0 = pack3(seq9);
    run3("midreset", seq9, 1'b0, 0, -1, 20);
    @(negedge clk);
    check("after_reset.busy", 32'(busy0), 32'd0);
    a_flat0 = pack3(ones);
    b_flat0 = pack3(ones);
    run3("post_reset", threes, 1'b0, 0, -1, -1);

    // N=4, DATA_W=4: A[i][k] = i+k, B = I, so C = A
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        a_flat1[(i*4+k)*4 +: 4] = 4'(i + k);
        b_flat1[(i*4+k)*4 +: 4] = (i == k) ? 4'd1 : 4'd0;
      end
    end
    ready1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0; idx = 0; done_c = -1;
    while (cyc < 300 && done_c < 0) begin
      if (valid1) begin
        check("n4.data", 32'(data1), 32'((idx / 4) + (idx % 4)));
        check("n4.row",  32'(row1),  32'(idx / 4));
        check("n4.col",  32'(col1),  32'(idx % 4));
        idx++;
      end
      if (done1) done_c = cyc;
      @(negedge clk);
      cyc++;
    end
    check("n4.count",      32'(idx),    32'd16);
    check("n4.done_cycle", 32'(done_c), 32'd81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Parametrised, sequential N×N matrix multiplier for the convolution datapath. It is the successor to the fixed 3×3 multiplier. It latches two flattened unsigned operand matrices on `start` and computes C = A·B with a single multiply-accumulate unit, one product per cycle. Each element of C is streamed out in row-major order over a valid/ready handshake.

## Interface
- `N`, 3: matrix dimension, 2..16.
- `DATA_W`, 8: operand element width, unsigned.
- `RES_W`, 16: output element width.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `a_flat`  in  N*N*DATA_W: A, element [i][k] at bits (i*N+k)*DATA_W +: DATA_W.
- `b_flat`  in  N*N*DATA_W: B, same packing.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last element is accepted.
- `out_valid`  out  1: `out_data` holds a result element.
- `out_ready`  in  1: consumer accepts the element.
- `out_data`  out  RES_W: element C[out_row][out_col].
- `out_row`, `out_col`  out  IDX_W each (IDX_W = max(1, clog2 N)): element indices.
- `out_sat`  out  1: element was clamped. Present only with `MATMUL_SAT_EN`.

## Operation
- States are IDLE, MAC, OUT and DONE.
- **IDLE**: when `start` is high at an edge:
  - `a_flat`/`b_flat` are copied into internal registers.
  - i, j, k and the accumulator are cleared.
  - The block goes to MAC.
- **MAC**: each cycle adds a[i][k]·b[k][j] into the accumulator and increments k.
  - On the edge that adds k=N-1, `out_data`/`out_row`/`out_col` are registered from the final sum and i, j.
  - The block then goes to OUT.
- **OUT**: `out_valid` is high, and `out_data` and the indices are held stable until `out_valid && out_ready` at an edge.
  - On acceptance of the last element (i=j=N-1): go to DONE.
  - Otherwise: j increments, and wraps to 0 with i incrementing when it passes N-1. The accumulator and k clear, and the block returns to MAC.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Arithmetic:
  - The product is 2·DATA_W bits.
  - The accumulator is ACC_W = 2·DATA_W + clog2(N) bits and never overflows.
  - The output reduction from ACC_W to RES_W is set by the Configuration section.
- `start` while `busy` is ignored. Input changes after the latch edge do not affect the result.
- Reset at any time, including mid-matrix: state goes to IDLE and all counters and the accumulator clear. `busy`, `done`, `out_valid`, `out_data`, `out_row`, `out_col` and `out_sat` all reset to 0.

## Timing
- Call the start edge cycle 0. The first `out_valid` rises after edge N, i.e. is visible in cycle N.
- Each element takes N MAC cycles plus at least 1 OUT cycle.
- With `out_ready` tied high, a full matrix takes 1 + N·N·(N+1) cycles from start to `done`. For N=3 that is 37 cycles, with `done` in cycle 37.
- Backpressure stalls only in OUT. There are no bubbles beyond the stall itself.
- `out_valid` is never deasserted without acceptance, except by reset.

## Configuration
- **`MATMUL_SAT_EN` defined**:
  - If the accumulator exceeds 2^RES_W−1, `out_data` = 2^RES_W−1 and `out_sat`=1 for that element.
  - Otherwise `out_sat`=0.
- **`MATMUL_SAT_EN` undefined**:
  - `out_data` = accumulator mod 2^RES_W, a plain truncation.
  - The `out_sat` port is absent.

## Structure
- Package `matmul_pkg` holds:
  - the state enum type `mm_state_t` (IDLE, MAC, OUT, DONE);
  - a width helper function for IDX_W/ACC_W.
- Sub-module `mat_mac` holds the multiplier, the accumulator register, and its clear/enable, with ACC_W as a parameter.
- Operand registers, index counters and the FSM live in the top level.

## Test plan
- **Identity**: N=3, A=I, B=1..9 row-major, `out_ready`=1 → outputs 1..9 with correct row/col, and `done` in cycle 37.
- **Overflow**: A=B=all 255, N=3 → with `MATMUL_SAT_EN` all nine outputs are 65535 with `out_sat`=1; without it all nine are 64003.
- **Backpressure**: A=B=all 1, `out_ready` low for 5 cycles in each OUT → every element is 3, held stable while stalled, none lost or duplicated.
- **Start while busy**: pulse `start` with new operands at cycle 10 → ignored, and the results match the original operands.
- **Reset mid-operation**: assert `reset` at cycle 20 → all outputs 0 immediately. A new start then gives a correct full result.
- **N=4, DATA_W=4**: A[i][k]=i+k, B=I → C=A, emitted in row-major order.
